// File: rtl/seg7_scan_driver.sv
// Purpose: 8-digit multiplexed 7-segment driver; hex or double-dabble decimal view of data.
// Latency: data sampled in LOAD reaches the display register 1 cycle later (hex) or 33 (dec).
// Backpressure: none; free-running, data changes outside LOAD wait for the next LOAD.
// Optional build macro SEG_LZB_EN enables leading-zero blanking on digits 1..7.
module seg7_scan_driver #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        dec_mode,
  input  logic [31:0] data,
  output logic [7:0]  SEG,
  output logic [7:0]  AN,
  output logic        ovf,
  output logic        upd
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {LOAD, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   dat_q, dat_d;
  logic          dec_q, dec_d;
  logic [31:0]   bin_q, bin_d;
  logic [39:0]   bcd_q, bcd_d;
  logic [39:0]   bcd_adj;
  logic [4:0]    cnt_q, cnt_d;
  logic [31:0]   disp_q, disp_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] pre_q;
  logic [2:0]    idx_q;
  logic [7:0]    seg_q, seg_d;
  logic [7:0]    an_q, an_d;
  logic [3:0]    nib;
  logic          blank;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
  function automatic logic [6:0] enc7(input logic [3:0] v);
    case (v)
      4'h0: enc7 = 7'h40;
      4'h1: enc7 = 7'h79;
      4'h2: enc7 = 7'h24;
      4'h3: enc7 = 7'h30;
      4'h4: enc7 = 7'h19;
      4'h5: enc7 = 7'h12;
      4'h6: enc7 = 7'h02;
      4'h7: enc7 = 7'h78;
      4'h8: enc7 = 7'h00;
      4'h9: enc7 = 7'h10;
      4'hA: enc7 = 7'h08;
      4'hB: enc7 = 7'h03;
      4'hC: enc7 = 7'h46;
      4'hD: enc7 = 7'h21;
      4'hE: enc7 = 7'h06;
      default: enc7 = 7'h0E;
    endcase
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM next-state and datapath; the mode is taken from the shadow
  // register so a live dec_mode change cannot mix modes within one conversion.
  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    dec_d   = dec_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    upd     = 1'b0;
    case (state_q)
      LOAD: begin
        dat_d   = data;
        dec_d   = dec_mode;
        bin_d   = data;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = dec_mode ? SHIFT : DONE;
      end
      SHIFT: begin
        bcd_d = {bcd_adj[38:0], bin_q[31]};
        bin_d = {bin_q[30:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
        end
      end
      DONE: begin
        disp_d  = dec_q ? bcd_q[31:0] : dat_q;
        ovf_d   = dec_q & (|bcd_q[39:32]);
        upd     = 1'b1;
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Conversion state registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= LOAD;
      dat_q   <= '0;
      dec_q   <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      dec_q   <= dec_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
    end
  end

  // Scan prescaler: one digit slot every SCAN_DIV board clocks.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (pre_q == PRE_MAX) begin
      pre_q <= '0;
      idx_q <= idx_q + 3'd1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // Segment/anode pattern for the digit currently selected by the scanner.
  always_comb begin
    nib = disp_q[{idx_q, 2'b00} +: 4];
`ifdef SEG_LZB_EN
    blank = (idx_q != 3'd0) && ((disp_q >> {idx_q, 2'b00}) == 32'd0);
`else
    blank = 1'b0;
`endif
    seg_d = blank ? 8'hFF : {1'b1, enc7(nib)};
    an_d  = ~(8'b1 << idx_q);
  end

  // Registered display outputs, all dark while in reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      seg_q <= 8'hFF;
      an_q  <= 8'hFF;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign SEG = seg_q;
  assign AN  = an_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with SCAN_DIV=2: directed vectors feed a scoreboard
// queue, a monitor process checks each fresh display reload and the digit scan.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        clr;
  logic        dec_mode;
  logic [31:0] data;
  logic [7:0]  SEG;
  logic [7:0]  AN;
  logic        ovf;
  logic        upd;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int issued   = 0;

  typedef struct {
    logic [31:0] disp;
    logic        ovf;
    int          period;
  } exp_t;

  exp_t sbq[$];

  seg7_scan_driver #(.SCAN_DIV(2)) dut (
    .clk      (clk),
    .clr      (clr),
    .dec_mode (dec_mode),
    .data     (data),
    .SEG      (SEG),
    .AN       (AN),
    .ovf      (ovf),
    .upd      (upd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Counts negedges until upd is seen high, bounded.
  task automatic wait_upd(input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!upd && n < 200);
    n_checks++;
    if (!upd) begin
      n_errors++;
      $display("FAIL %s: upd not seen within %0d cycles", nm, n);
    end
  endtask

  task automatic wait_an(input string nm, input logic [7:0] v);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (AN !== v && n < 64);
    n_checks++;
    if (AN !== v) begin
      n_errors++;
      $display("FAIL %s: AN stuck at %h, expected %h", nm, AN, v);
    end
  endtask

  // Expected SEG for digit k of a hand-computed display value.
  function automatic logic [7:0] exp_seg(input logic [31:0] d, input int k);
    logic [3:0] nb;
    nb = d[4*k +: 4];
`ifdef SEG_LZB_EN
    if (k != 0 && (d >> (4*k)) == 32'd0) return 8'hFF;
`endif
    case (nb)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction

  // Monitor: for each expectation, skip the possibly stale reload, then check
  // the reload period, ovf, and a full 16-cycle digit scan.
  initial begin
    exp_t e;
    int   n;
    logic [7:0] an_exp;
    forever begin
      while (sbq.size() == 0) @(negedge clk);
      e = sbq.pop_front();
      wait_upd("upd_stale", n);
      wait_upd("upd_fresh", n);
      wait_upd("upd_next", n);
      chk("upd_period", n, e.period);
      @(posedge clk);
      #1;
      chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
      wait_an("an_wait_7F", 8'h7F);
      wait_an("an_wait_FE", 8'hFE);
      for (int s = 0; s < 16; s++) begin
        if (s > 0) @(negedge clk);
        an_exp = ~(8'b1 << (s / 2));
        chk($sformatf("an_walk_s%0d", s), {24'd0, AN}, {24'd0, an_exp});
        chk($sformatf("seg_d%0d_s%0d", s / 2, s), {24'd0, SEG},
            {24'd0, exp_seg(e.disp, s / 2)});
      end
      done_cnt++;
    end
  end

  task automatic issue(input logic dm, input logic [31:0] d,
                       input logic [31:0] exp_disp, input logic exp_ovf);
    exp_t e;
    int   n;
    @(negedge clk);
    dec_mode = dm;
    data     = d;
    e.disp   = exp_disp;
    e.ovf    = exp_ovf;
    e.period = dm ? 34 : 2;
    sbq.push_back(e);
    issued++;
    n = 0;
    while (done_cnt != issued && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (done_cnt != issued) begin
      n_errors++;
      $display("FAIL monitor_stall: done %0d of %0d", done_cnt, issued);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clr      = 1'b1;
    dec_mode = 1'b0;
    data     = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_seg", {24'd0, SEG}, 32'hFF);
    chk("rst_an",  {24'd0, AN},  32'hFF);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_upd", {31'd0, upd}, 32'd0);
    clr = 1'b0;
    @(negedge clk);
    chk("first_an",  {24'd0, AN},  32'hFE);
    chk("first_seg", {24'd0, SEG}, 32'hC0);

    // Directed vectors: mode, data, hand-computed display value, ovf.
    issue(1'b0, 32'h0123ABCD, 32'h0123ABCD, 1'b0);
    issue(1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 32'h000000A5, 32'h000000A5, 1'b0);
    issue(1'b0, 32'h00000000, 32'h00000000, 1'b0);
    issue(1'b1, 32'd12345678, 32'h12345678, 1'b0);
    issue(1'b1, 32'd100,      32'h00000100, 1'b0);
    issue(1'b1, 32'd99999999, 32'h99999999, 1'b0);
    issue(1'b1, 32'd100000000, 32'h00000000, 1'b1);

    // Reset in the middle of a decimal conversion while ovf is high.
    wait_upd("clr_sync", n);
    repeat (10) @(negedge clk);
    clr = 1'b1;
    #1;
    chk("clr_seg", {24'd0, SEG}, 32'hFF);
    chk("clr_an",  {24'd0, AN},  32'hFF);
    chk("clr_ovf", {31'd0, ovf}, 32'd0);
    chk("clr_upd", {31'd0, upd}, 32'd0);
    repeat (3) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("clr_rel_an",  {24'd0, AN},  32'hFE);
    chk("clr_rel_seg", {24'd0, SEG}, 32'hC0);
    wait_upd("clr_rel_upd", n);
    chk("clr_rel_latency", n + 1, 33);

    issue(1'b1, 32'hFFFFFFFF, 32'h94967295, 1'b1);

    // Switch to hex during SHIFT: current conversion stays decimal.
    wait_upd("tog_sync", n);
    repeat (5) @(negedge clk);
    dec_mode = 1'b0;
    wait_upd("tog_done", n);
    chk("tog_dec_period", n + 5, 34);
    @(posedge clk);
    #1;
    chk("tog_dec_ovf", {31'd0, ovf}, 32'd1);
    wait_upd("tog_hex", n);
    chk("tog_hex_period", n, 2);
    @(posedge clk);
    #1;
    chk("tog_hex_ovf", {31'd0, ovf}, 32'd0);
    issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
